// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its fetch buffer.
package if_fetch_stage_pkg;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;

    typedef logic [ADDR_W-1:0] InstAddrBus;
    typedef logic [INST_W-1:0] InstBus;

    localparam InstAddrBus RESET_PC = 64'h0000_0000_8000_0000;
    localparam InstBus     NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Two-entry synchronous FIFO holding fetched {pc, inst, excp} records.
module if_fetch_buf
    import if_fetch_stage_pkg::*;
#(
    parameter int W = ADDR_W + INST_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic         flush_load_i,
    input  logic [W-1:0] push_data_i,
    input  logic [W-1:0] load_data_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] mem_q [2];
    logic         head_q, head_d;
    logic         tail_q, tail_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            // A flush-load leaves exactly one entry sitting in slot 0.
            head_d  = 1'b0;
            tail_d  = flush_load_i;
            count_d = flush_load_i ? 2'd1 : 2'd0;
        end else begin
            head_d  = head_q + pop_i;
            tail_d  = tail_q + push_i;
            count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (flush_i) begin
                if (flush_load_i) begin
                    mem_q[0] <= load_data_i;
                end
            end else if (push_i) begin
                mem_q[tail_q] <= push_data_i;
            end
        end
    end

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[head_q];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational ROM, buffers
// fetched words and hands them to decode over a valid/ready handshake.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = if_fetch_stage_pkg::ADDR_W,
    parameter int                INST_W   = if_fetch_stage_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = if_fetch_stage_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_excp
);

    localparam int ENT_W = ADDR_W + INST_W + 1;

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;

    logic              buf_full;
    logic              buf_empty;
    logic [ENT_W-1:0]  buf_head;
    logic              pop;
    logic              take;
    logic              redirect_bad;

    assign pop          = id_valid & id_ready;
    assign take         = (state_q == FETCH) & ~redirect_valid & (~buf_full | pop);
    assign redirect_bad = redirect_valid & is_misaligned(redirect_pc[1:0]);

    assign rom_ce   = take;
    assign rom_addr = pc_q;

    // Redirect outranks everything: it retargets the PC and picks the next state
    // from target alignment, regardless of whether we were idle, fetching or halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= redirect_bad ? HALT : FETCH;
        end else begin
            if (take) begin
                pc_q <= pc_q + ADDR_W'(4);
            end
            case (state_q)
                IDLE:    state_q <= FETCH;
                FETCH:   state_q <= FETCH;
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    if_fetch_buf #(
        .W (ENT_W)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .push_i       (take),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .flush_load_i (redirect_bad),
        .push_data_i  ({pc_q, rom_inst, 1'b0}),
        .load_data_i  ({redirect_pc, {INST_W{1'b0}}, 1'b1}),
        .full_o       (buf_full),
        .empty_o      (buf_empty),
        .head_o       (buf_head)
    );

    assign id_valid = ~buf_empty;
    assign {id_pc, id_inst, id_excp} = buf_empty ? {ENT_W{1'b0}} : buf_head;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, wrap sequence, then random
// traffic checked every cycle against a queue-based reference model.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    localparam logic [63:0] R = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [63:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic        id_excp;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .rom_ce         (rom_ce),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_excp        (id_excp)
    );

    // ROM returns incrementing word indices, distinct per address.
    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return a[33:2];
    endfunction
    assign rom_inst = rom_word(rom_addr);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of entries plus pc and a coarse mode.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        excp;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    int          m_mode;   // 0 = post-reset bubble, 1 = running, 2 = halted
    bit          m_known = 1'b0;

    function automatic logic model_ce();
        return (m_mode == 1) && !redirect_valid && ((mq.size() < 2) || id_ready);
    endfunction

    task automatic model_check();
        ent_t h;
        if (!m_known) return;
        h = '{pc: 64'd0, inst: 32'd0, excp: 1'b0};
        if (mq.size() != 0) h = mq[0];
        chk("m_rom_ce",   64'(rom_ce),   64'(model_ce()));
        chk("m_rom_addr", rom_addr,      m_pc);
        chk("m_id_valid", 64'(id_valid), 64'(mq.size() != 0));
        chk("m_id_pc",    id_pc,         h.pc);
        chk("m_id_inst",  64'(id_inst),  64'(h.inst));
        chk("m_id_excp",  64'(id_excp),  64'(h.excp));
    endtask

    task automatic model_update();
        logic ce;
        if (rst) begin
            mq.delete();
            m_pc    = R;
            m_mode  = 0;
            m_known = 1'b1;
            return;
        end
        if (!m_known) return;
        ce = model_ce();
        if ((mq.size() != 0) && id_ready) void'(mq.pop_front());
        if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                mq.push_back('{pc: redirect_pc, inst: 32'd0, excp: 1'b1});
                m_mode = 2;
            end else begin
                m_mode = 1;
            end
        end else begin
            if (ce) begin
                mq.push_back('{pc: m_pc, inst: rom_word(m_pc), excp: 1'b0});
                m_pc = m_pc + 64'd4;
            end
            if (m_mode == 0) m_mode = 1;
        end
    endtask

    task automatic apply(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy);
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        #1;
    endtask

    task automatic advance();
        model_check();
        model_update();
        @(posedge clk);
    endtask

    typedef struct {
        logic        r, rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        chk_en;
        logic        ce;
        logic [63:0] addr;
        logic        v;
        logic [63:0] pc;
        logic        ex;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy,
                       input logic c, input logic ce, input logic [63:0] addr,
                       input logic v, input logic [63:0] pc, input logic ex);
        tbl.push_back('{r: r, rv: rv, rpc: rpc, rdy: rdy, chk_en: c, ce: ce,
                        addr: addr, v: v, pc: pc, ex: ex});
    endtask

    initial begin
        logic [31:0] exp_inst;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        // rst rdyv rpc rdy | chk ce addr valid pc excp
        add(1, 0, 0,          1, 0, 0, 0,          0, 0,          0);
        add(0, 0, 0,          0, 1, 0, R,          0, 0,          0);
        add(0, 0, 0,          0, 1, 1, R,          0, 0,          0);
        add(0, 0, 0,          0, 1, 1, R + 4,      1, R,          0);
        add(0, 0, 0,          0, 1, 0, R + 8,      1, R,          0);
        add(0, 0, 0,          0, 1, 0, R + 8,      1, R,          0);
        add(0, 0, 0,          1, 1, 1, R + 8,      1, R,          0);
        add(0, 0, 0,          1, 1, 1, R + 12,     1, R + 4,      0);
        add(0, 1, R + 'h42,   1, 1, 0, R + 16,     1, R + 8,      0);
        add(0, 0, 0,          0, 1, 0, R + 'h42,   1, R + 'h42,   1);
        add(0, 0, 0,          1, 1, 0, R + 'h42,   1, R + 'h42,   1);
        add(0, 0, 0,          1, 1, 0, R + 'h42,   0, 0,          0);
        add(0, 1, R + 'h100,  0, 1, 0, R + 'h42,   0, 0,          0);
        add(0, 0, 0,          0, 1, 1, R + 'h100,  0, 0,          0);
        add(0, 0, 0,          0, 1, 1, R + 'h104,  1, R + 'h100,  0);
        add(0, 1, R + 'h40,   1, 1, 0, R + 'h108,  1, R + 'h100,  0);
        add(0, 0, 0,          1, 1, 1, R + 'h40,   0, 0,          0);
        add(0, 0, 0,          0, 1, 1, R + 'h44,   1, R + 'h40,   0);
        add(1, 0, 0,          0, 1, 0, R + 'h48,   1, R + 'h40,   0);
        add(0, 0, 0,          1, 1, 0, R,          0, 0,          0);
        add(0, 0, 0,          1, 1, 1, R,          0, 0,          0);
        add(0, 0, 0,          1, 1, 1, R + 4,      1, R,          0);

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            if (tbl[i].chk_en) begin
                exp_inst = (tbl[i].v && !tbl[i].ex) ? rom_word(tbl[i].pc) : 32'd0;
                chk($sformatf("tbl%0d_rom_ce", i),   64'(rom_ce),   64'(tbl[i].ce));
                chk($sformatf("tbl%0d_rom_addr", i), rom_addr,      tbl[i].addr);
                chk($sformatf("tbl%0d_id_valid", i), 64'(id_valid), 64'(tbl[i].v));
                chk($sformatf("tbl%0d_id_pc", i),    id_pc,         tbl[i].pc);
                chk($sformatf("tbl%0d_id_inst", i),  64'(id_inst),  64'(exp_inst));
                chk($sformatf("tbl%0d_id_excp", i),  64'(id_excp),  64'(tbl[i].ex));
            end
            advance();
        end

        // PC wrap from the top of the address space back to zero.
        apply(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        advance();
        apply(0, 0, 0, 1);
        chk("wrap_ce",   64'(rom_ce), 64'd1);
        chk("wrap_addr", rom_addr,    64'hFFFF_FFFF_FFFF_FFFC);
        advance();
        apply(0, 0, 0, 1);
        chk("wrap_addr0", rom_addr,    64'd0);
        chk("wrap_pc",    id_pc,       64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_excp",  64'(id_excp), 64'd0);
        advance();
        apply(0, 0, 0, 1);
        chk("wrap_next_pc", id_pc, 64'd0);
        advance();

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            logic        r, rv, rdy;
            logic [63:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 5))
                0:       rpc = R + 64'($urandom_range(0, 255) * 4) + 64'($urandom_range(1, 3));
                1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
                default: rpc = R + 64'($urandom_range(0, 255) * 4);
            endcase
            apply(r, rv, rpc, rdy);
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
